uart_port: RTL and testbench

Device-side UART transceiver sitting behind the CPU's serial-port address (0xBF00 data, 0xBF01 status). It answers the memory controller's active-low `rdn`/`wrn` strobes and produces the `data_ready`, `tbre` and `tsre` status lines that the controller polls. It serialises written bytes onto `txd` and deserialises `rxd` into a one-byte receive buffer. The frame format is 8N1, LSB first.

---
 rtl/uart_port.sv | 263 ++++++++++++++++++++++++++
 tb/tb_uart_port.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port.sv
// uart_port: device-side 8N1 UART transceiver behind the CPU serial-port address.
//   clk_50MHz     system clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   data_i        byte written on a wrn event
//   data_o        receive buffer contents
//   rdn / wrn     active-low read / write strobes (one event per low pulse)
//   data_ready    receive buffer holds an unread byte
//   tbre / tsre   transmit holding register empty / transmit shifter idle
//   rxd / txd     serial input (asynchronous) / serial output (idle high)
//   rx_overrun    sticky: byte received while data_ready was already set
//   rx_frame_err  sticky: stop bit sampled low
module uart_port #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  input  logic       rdn,
  input  logic       wrn,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  input  logic       rxd,
  output logic       txd,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Strobe edge detection
  logic rdn_q, wrn_q;
  logic rd_ev, wr_ev;
  assign rd_ev = rdn_q & ~rdn;
  assign wr_ev = wrn_q & ~wrn;

  // Transmit state
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        tbre_q, tbre_d;
  logic        tsre_q, tsre_d;
  logic        txd_q, txd_d;

  // Receive state
  logic        rx_meta_q, rx_s_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic        ready_q, ready_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;
  logic        rx_load, rx_bad_stop;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    tbre_d     = tbre_q;
    tsre_d     = tsre_q;
    txd_d      = txd_q;

    // A write and a holding-register drain never coincide: they need opposite tbre_q.
    if (wr_ev && tbre_q) begin
      hold_d = data_i;
      tbre_d = 1'b0;
    end

    unique case (tx_state_q)
      TxIdle: begin
        if (!tbre_q) begin
          tx_shift_d = hold_q;
          tbre_d     = 1'b1;
          tsre_d     = 1'b0;
          txd_d      = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TxStop;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            txd_d    = tx_shift_q[tx_idx_d];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (!tbre_q) begin
            // Chain straight into the next frame with no idle gap.
            tx_shift_d = hold_q;
            tbre_d     = 1'b1;
            txd_d      = 1'b0;
            tx_state_d = TxStart;
          end else begin
            tsre_d     = 1'b1;
            tx_state_d = TxIdle;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_load     = 1'b0;
    rx_bad_stop = 1'b0;

    unique case (rx_state_q)
      RxIdle: begin
        if (!rx_s_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          // Line back high at mid-start-bit: treat as a glitch.
          rx_state_d = rx_s_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d             = '0;
          rx_shift_d[rx_idx_q] = rx_s_q;
          if (rx_idx_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d    = '0;
          rx_state_d  = RxIdle;
          rx_load     = rx_s_q;
          rx_bad_stop = ~rx_s_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
    endcase
  end

  // Receive buffer and status flags; a set in the same cycle as a read wins.
  always_comb begin
    rbuf_d  = rbuf_q;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    ferr_d  = ferr_q;
    if (rd_ev) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
    end
    if (rx_load) begin
      rbuf_d  = rx_shift_q;
      ready_d = 1'b1;
      if (ready_q && !rd_ev) begin
        ovr_d = 1'b1;
      end
    end
    if (rx_bad_stop) begin
      ferr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      rdn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      hold_q     <= '0;
      tbre_q     <= 1'b1;
      tsre_q     <= 1'b1;
      txd_q      <= 1'b1;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rbuf_q     <= '0;
      ready_q    <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rdn_q      <= rdn;
      wrn_q      <= wrn;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      tbre_q     <= tbre_d;
      tsre_q     <= tsre_d;
      txd_q      <= txd_d;
      rx_meta_q  <= rxd;
      rx_s_q     <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rbuf_q     <= rbuf_d;
      ready_q    <= ready_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_o       = rbuf_q;
  assign data_ready   = ready_q;
  assign tbre         = tbre_q;
  assign tsre         = tsre_q;
  assign txd          = txd_q;
  assign rx_overrun   = ovr_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_port.sv
// tb_uart_port: directed, table-driven bench for uart_port with CLKS_PER_BIT = 8.
module tb_uart_port;

  localparam int unsigned Cpb = 8;

  logic       clk;
  logic       rst;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       rdn, wrn;
  logic       data_ready, tbre, tsre;
  logic       rxd, txd;
  logic       rx_overrun, rx_frame_err;

  int checks   = 0;
  int failures = 0;
  int tx_bad   = 0;

  uart_port #(.CLKS_PER_BIT(Cpb)) dut (
    .clk_50MHz   (clk),
    .rst         (rst),
    .data_i      (data_i),
    .data_o      (data_o),
    .rdn         (rdn),
    .wrn         (wrn),
    .data_ready  (data_ready),
    .tbre        (tbre),
    .tsre        (tsre),
    .rxd         (rxd),
    .txd         (txd),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame on txd as {stop, d7..d0, start}; bit 0 is sent first.
  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       do_read;
    logic       exp_ready;
    logic [7:0] exp_data;
    logic       exp_ovr;
    logic       exp_ferr;
  } rx_vec_t;

  tx_vec_t tx_tab [4];
  rx_vec_t rx_tab [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (!(tbre === 1'b1 && tsre === 1'b1) && n < 1000) begin
      tick();
      n++;
    end
    check("tx_idle_timeout", 32'(n < 1000), 32'd1);
  endtask

  task automatic tx_cyc(input logic exp);
    if (txd !== exp) tx_bad++;
    tick();
  endtask

  task automatic send_tx(input tx_vec_t v);
    int bad;
    wrn    = 1'b0;
    data_i = v.data;
    tick();
    check($sformatf("tx_%02h_tbre_after_wr", v.data), 32'(tbre), 32'd0);
    wrn    = 1'b1;
    data_i = 8'h00;
    tick();
    check($sformatf("tx_%02h_tbre_reload", v.data), 32'(tbre), 32'd1);
    check($sformatf("tx_%02h_tsre_busy", v.data), 32'(tsre), 32'd0);
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int c = 0; c < Cpb; c++) begin
        if (txd !== v.seq[i]) bad++;
        if (i == 9 && c == Cpb - 1) begin
          check($sformatf("tx_%02h_tsre_last", v.data), 32'(tsre), 32'd0);
        end
        tick();
      end
      check($sformatf("tx_%02h_bit%0d", v.data, i), 32'(bad), 32'd0);
    end
    check($sformatf("tx_%02h_tsre_done", v.data), 32'(tsre), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    repeat (Cpb) tick();
    for (int b = 0; b < 8; b++) begin
      rxd = d[b];
      repeat (Cpb) tick();
    end
    rxd = stop;
    repeat (Cpb) tick();
    rxd = 1'b1;
  endtask

  initial begin
    logic [19:0] two;
    int          bad;

    tx_tab[0] = '{8'hA5, 10'h34A};
    tx_tab[1] = '{8'h00, 10'h200};
    tx_tab[2] = '{8'hFF, 10'h3FE};
    tx_tab[3] = '{8'h3C, 10'h278};

    rx_tab[0] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
    rx_tab[1] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    rx_tab[2] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0};
    rx_tab[3] = '{8'h77, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1};

    rst    = 1'b1;
    rdn    = 1'b1;
    wrn    = 1'b1;
    rxd    = 1'b1;
    data_i = 8'h00;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values held while idle
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (txd !== 1'b1 || tbre !== 1'b1 || tsre !== 1'b1 || data_ready !== 1'b0 ||
          data_o !== 8'h00 || rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) bad++;
      tick();
    end
    check("reset_idle_cycles_bad", 32'(bad), 32'd0);
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_tbre", 32'(tbre), 32'd1);
    check("reset_tsre", 32'(tsre), 32'd1);
    check("reset_data_ready", 32'(data_ready), 32'd0);
    check("reset_data_o", 32'(data_o), 32'h00);

    // Short low glitch on rxd must not start a reception
    rxd = 1'b0;
    repeat (3) tick();
    rxd = 1'b1;
    repeat (60) tick();
    check("glitch_data_ready", 32'(data_ready), 32'd0);
    check("glitch_frame_err", 32'(rx_frame_err), 32'd0);

    // Single-frame transmit vectors
    for (int v = 0; v < 4; v++) begin
      wait_tx_idle();
      repeat (5) tick();
      send_tx(tx_tab[v]);
    end

    // 0x3C then 0xC3 back-to-back; third write while tbre=0 is dropped
    wait_tx_idle();
    repeat (5) tick();
    two    = {10'h386, 10'h278};
    tx_bad = 0;
    wrn    = 1'b0;
    data_i = 8'h3C;
    tick();
    wrn = 1'b1;
    tick();
    wrn    = 1'b0;
    data_i = 8'hC3;
    tx_cyc(two[0]);
    wrn    = 1'b1;
    data_i = 8'h99;
    tx_cyc(two[0]);
    check("b2b_tbre_full", 32'(tbre), 32'd0);
    wrn = 1'b0;
    tx_cyc(two[0]);
    wrn    = 1'b1;
    data_i = 8'h00;
    tx_cyc(two[0]);
    for (int p = 4; p < 20 * Cpb; p++) begin
      if (p == 10 * Cpb - 1) check("b2b_tsre_mid", 32'(tsre), 32'd0);
      tx_cyc(two[p / Cpb]);
    end
    check("b2b_frames_bad_cycles", 32'(tx_bad), 32'd0);
    check("b2b_tsre_done", 32'(tsre), 32'd1);
    check("b2b_tbre_done", 32'(tbre), 32'd1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (txd !== 1'b1 || tsre !== 1'b1) bad++;
      tick();
    end
    check("b2b_third_write_dropped", 32'(bad), 32'd0);

    // Receive vectors
    for (int v = 0; v < 4; v++) begin
      send_rx(rx_tab[v].data, rx_tab[v].stop);
      check($sformatf("rx%0d_data_ready", v), 32'(data_ready), 32'(rx_tab[v].exp_ready));
      check($sformatf("rx%0d_data_o", v), 32'(data_o), 32'(rx_tab[v].exp_data));
      check($sformatf("rx%0d_overrun", v), 32'(rx_overrun), 32'(rx_tab[v].exp_ovr));
      check($sformatf("rx%0d_frame_err", v), 32'(rx_frame_err), 32'(rx_tab[v].exp_ferr));
      if (rx_tab[v].do_read) begin
        rdn = 1'b0;
        tick();
        check($sformatf("rx%0d_read_ready", v), 32'(data_ready), 32'd0);
        check($sformatf("rx%0d_read_overrun", v), 32'(rx_overrun), 32'd0);
        check($sformatf("rx%0d_read_frame_err", v), 32'(rx_frame_err), 32'd0);
        check($sformatf("rx%0d_read_data_o", v), 32'(data_o), 32'(rx_tab[v].exp_data));
        rdn = 1'b1;
        repeat (20) tick();
      end
    end

    // Reset in the middle of a transmitted frame
    wait_tx_idle();
    wrn    = 1'b0;
    data_i = 8'h00;
    tick();
    wrn = 1'b1;
    repeat (20) tick();
    check("midrst_pre_txd", 32'(txd), 32'd0);
    check("midrst_pre_tsre", 32'(tsre), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_tbre", 32'(tbre), 32'd1);
    check("midrst_tsre", 32'(tsre), 32'd1);
    check("midrst_data_o", 32'(data_o), 32'h00);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (txd !== 1'b1 || tsre !== 1'b1 || tbre !== 1'b1) bad++;
      tick();
    end
    check("midrst_stays_idle", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
